// File: rtl/audio_capture_writer.sv
// I2S ADC capture into on-chip memory: one {left,right} 32-bit word per stereo frame, one-shot or ring.
// Optional peak-level tracker enabled with `define AUDIO_PEAK_EN.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_SYNC    | armed, waiting for LRCK high->low (start of a left channel)
// S_CAPTURE | writing each completed frame to memory
// S_DONE    | one-shot buffer full; done pulses for this cycle
module audio_capture_writer #(
    parameter int SAMPLE_BITS = 16,
    parameter int ADDR_W      = 17,
    parameter int BASE_ADDR   = 0,
    parameter int BUF_WORDS   = 1024
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              audio_ADCDAT,
    input  logic              audio_ADCLRCK,
    input  logic              audio_BCLK,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable
`ifdef AUDIO_PEAK_EN
    ,
    output logic [15:0]       peak_level
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CAPTURE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(BUF_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [4:0]        NBITS    = 5'(SAMPLE_BITS);

    state_t            state_q, state_d;
    logic [1:0]        dat_s_q, lrck_s_q;
    logic [2:0]        bclk_s_q;
    logic              lrck_prev_q, lrck_prev_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [15:0]       left_q, left_d, right_q, right_d;
    logic              left_done_q, left_done_d;
    logic              ring_q, ring_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              write_q, write_d;
    logic              bclk_rise, lrck, sdat, lrck_fall, word_ready, start_acc;
    logic [3:0]        bit_idx;

    always_comb begin
        bclk_rise   = bclk_s_q[1] & ~bclk_s_q[2];
        lrck        = lrck_s_q[1];
        sdat        = dat_s_q[1];
        lrck_fall   = bclk_rise & lrck_prev_q & ~lrck;
        bit_idx     = 4'(5'd15 - bit_cnt_q);
        lrck_prev_d = lrck_prev_q;
        bit_cnt_d   = bit_cnt_q;
        left_d      = left_q;
        right_d     = right_q;
        left_done_d = left_done_q;
        word_ready  = 1'b0;
        if (bclk_rise) begin
            if (lrck != lrck_prev_q) begin
                // first bit after an LRCK change is the I2S one-bit delay slot
                lrck_prev_d = lrck;
                bit_cnt_d   = '0;
                if (lrck) begin
                    right_d = '0;
                end else begin
                    left_d      = '0;
                    left_done_d = 1'b0;
                end
            end else if (bit_cnt_q < NBITS) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (lrck) begin
                    right_d[bit_idx] = sdat;
                    if (bit_cnt_q == NBITS - 5'd1 && left_done_q) begin
                        word_ready  = 1'b1;
                        left_done_d = 1'b0;
                    end
                end else begin
                    left_d[bit_idx] = sdat;
                    if (bit_cnt_q == NBITS - 5'd1) left_done_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        start_acc = (state_q == S_IDLE || state_q == S_DONE) && start && !stop;
        write_d   = word_ready && (state_q == S_CAPTURE) && !stop;
        ring_d    = start_acc ? continuous : ring_q;
        wr_ptr_d  = wr_ptr_q;
        if (start_acc)
            wr_ptr_d = '0;
        else if (write_q)
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = start_acc ? S_SYNC : S_IDLE;
            S_SYNC: begin
                if (stop)           state_d = S_IDLE;
                else if (lrck_fall) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (stop)                                            state_d = S_IDLE;
                else if (write_q && wr_ptr_q == LAST_PTR && !ring_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == S_SYNC) || (state_q == S_CAPTURE);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            dat_s_q     <= '0;
            lrck_s_q    <= '0;
            bclk_s_q    <= '0;
            lrck_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            left_q      <= '0;
            right_q     <= '0;
            left_done_q <= 1'b0;
            ring_q      <= 1'b0;
            wr_ptr_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
        end else begin
            dat_s_q     <= {dat_s_q[0], audio_ADCDAT};
            lrck_s_q    <= {lrck_s_q[0], audio_ADCLRCK};
            bclk_s_q    <= {bclk_s_q[1:0], audio_BCLK};
            lrck_prev_q <= lrck_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            left_q      <= left_d;
            right_q     <= right_d;
            left_done_q <= left_done_d;
            ring_q      <= ring_d;
            wr_ptr_q    <= wr_ptr_d;
            write_q     <= write_d;
            if (write_d) begin
                addr_q  <= BASE + wr_ptr_q;
                wdata_q <= {left_q, right_d};
            end
        end
    end

    assign wr_ptr         = wr_ptr_q;
    assign mem_address    = addr_q;
    assign mem_writedata  = wdata_q;
    assign mem_chipselect = write_q;
    assign mem_clken      = write_q;
    assign mem_write      = write_q;
    assign mem_byteenable = {4{write_q}};

`ifdef AUDIO_PEAK_EN
    logic [15:0] peak_q, peak_d, abs_l, abs_r;

    function automatic logic [15:0] abs16(input logic [15:0] x);
        if (x == 16'h8000) return 16'h7FFF;
        else if (x[15])    return 16'(~x + 16'd1);
        else               return x;
    endfunction

    always_comb begin
        abs_l  = abs16(wdata_q[31:16]);
        abs_r  = abs16(wdata_q[15:0]);
        peak_d = peak_q;
        if (start_acc) begin
            peak_d = '0;
        end else if (write_q) begin
            if (abs_l > peak_d) peak_d = abs_l;
            if (abs_r > peak_d) peak_d = abs_r;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) peak_q <= '0;
        else             peak_q <= peak_d;
    end

    assign peak_level = peak_q;
`endif

endmodule
